// File: rtl/screen_field_writer.sv
// Renders NUM_FIELDS unsigned values as DIGITS decimal ASCII characters each frame, then relays
// a terminal character stream into the same memory. Define SCREEN_FIELD_LEADING_BLANK_EN to blank leading zeros.
module screen_field_writer #(
  parameter int NUM_FIELDS = 2,
  parameter int DIGITS     = 4,
  parameter int VAL_W      = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         run,
  input  logic [NUM_FIELDS*VAL_W-1:0]  field_val,
  input  logic [NUM_FIELDS*ADDR_W-1:0] field_base,
  output logic                         term_start,
  input  logic                         term_valid,
  input  logic [ADDR_W-1:0]            term_index,
  input  logic [7:0]                   term_data,
  input  logic                         term_done,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int K_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int D_W = 4;
  localparam logic [K_W-1:0]    K_LAST    = K_W'(NUM_FIELDS - 1);
  localparam logic [D_W-1:0]    D_LAST    = D_W'(DIGITS - 1);
  localparam logic [ADDR_W-1:0] UNITS_OFS = ADDR_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    DIGIT     = 3'd2,
    TERM_REQ  = 3'd3,
    TERM_WAIT = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [K_W-1:0]    k_r;
  logic [D_W-1:0]    d_r;
  logic [VAL_W-1:0]  work_r;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] digit_addr_s;
  logic [3:0]        digit_s;
  logic [7:0]        digit_char_s;

  // Units digit is written first, at the rightmost address of the field.
  assign base_s       = field_base[int'(k_r)*ADDR_W +: ADDR_W];
  assign digit_addr_s = base_s + UNITS_OFS - ADDR_W'(d_r);
  assign digit_s      = 4'(work_r % VAL_W'(10));

  // ASCII character for the current digit position.
  always_comb begin
    digit_char_s = 8'h30 + {4'd0, digit_s};
`ifdef SCREEN_FIELD_LEADING_BLANK_EN
    if ((work_r == {VAL_W{1'b0}}) && (d_r != {D_W{1'b0}})) begin
      digit_char_s = 8'h20;
    end else begin
      digit_char_s = 8'h30 + {4'd0, digit_s};
    end
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_s = LOAD;
        else     state_s = IDLE;
      end
      LOAD: state_s = DIGIT;
      DIGIT: begin
        if (d_r == D_LAST) begin
          if (k_r == K_LAST) state_s = TERM_REQ;
          else               state_s = LOAD;
        end else begin
          state_s = DIGIT;
        end
      end
      TERM_REQ: state_s = TERM_WAIT;
      TERM_WAIT: begin
        if (term_done) begin
          if (run) state_s = LOAD;
          else     state_s = IDLE;
        end else begin
          state_s = TERM_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Field index, digit counter and the snapshotted working value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k_r    <= {K_W{1'b0}};
      d_r    <= {D_W{1'b0}};
      work_r <= {VAL_W{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          work_r <= field_val[int'(k_r)*VAL_W +: VAL_W];
          d_r    <= {D_W{1'b0}};
        end
        DIGIT: begin
          work_r <= work_r / VAL_W'(10);
          d_r    <= d_r + 4'd1;
          if ((d_r == D_LAST) && (k_r != K_LAST)) begin
            k_r <= k_r + K_W'(1);
          end
        end
        TERM_WAIT: begin
          if (term_done) begin
            k_r <= {K_W{1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs; terminal characters pass straight through to the write port.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = {ADDR_W{1'b0}};
    wr_data    = 8'h00;
    term_start = 1'b0;
    frame_done = 1'b0;
    busy       = (state_r != IDLE);
    case (state_r)
      DIGIT: begin
        wr_en   = 1'b1;
        wr_addr = digit_addr_s;
        wr_data = digit_char_s;
      end
      TERM_REQ: term_start = 1'b1;
      TERM_WAIT: begin
        frame_done = term_done;
        if (term_valid) begin
          wr_en   = 1'b1;
          wr_addr = term_index;
          wr_data = term_data;
        end else begin
          wr_en   = 1'b0;
          wr_addr = {ADDR_W{1'b0}};
          wr_data = 8'h00;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_screen_field_writer.sv
// Self-checking bench for screen_field_writer: directed display cases plus randomized frames
// checked against a decimal-string reference model.
`timescale 1ns/1ps
module tb_screen_field_writer;
  localparam int NF = 2;
  localparam int D  = 4;
  localparam int VW = 32;
  localparam int AW = 8;
  localparam int NFR = 6;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic run = 1'b0;
  logic [NF*VW-1:0] field_val = '0;
  logic [NF*AW-1:0] field_base = '0;
  logic term_start;
  logic term_valid = 1'b0;
  logic [AW-1:0] term_index = '0;
  logic [7:0] term_data = 8'h00;
  logic term_done = 1'b0;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic frame_done;
  logic busy;

  typedef struct {logic [7:0] a; logic [7:0] d; int c;} wr_t;
  wr_t wq[$];
  wr_t exp_q[$];
  wr_t term_q[$];
  int  checks = 0, errors = 0, cyc = 0;
  int  ts_cnt = 0, fd_cnt = 0, busy_cyc = 0;
  bit  done_last = 1'b0, src_go = 1'b0, noise_en = 1'b0;

  screen_field_writer #(.NUM_FIELDS(NF), .DIGITS(D), .VAL_W(VW), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .run(run), .field_val(field_val), .field_base(field_base),
    .term_start(term_start), .term_valid(term_valid), .term_index(term_index),
    .term_data(term_data), .term_done(term_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .busy(busy));

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  // Monitor: every write, term_start and frame_done seen mid-cycle.
  initial forever begin
    @(negedge clock);
    if (wr_en === 1'b1) wq.push_back('{a: wr_addr, d: wr_data, c: cyc});
    if (term_start === 1'b1) begin ts_cnt++; src_go = 1'b1; end
    if (frame_done === 1'b1) fd_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  // Terminal source: streams term_q after each term_start, otherwise drives noise or idles.
  initial forever begin : term_source
    int n;
    @(posedge clock); #1;
    if (src_go) begin
      src_go = 1'b0;
      n = term_q.size();
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          @(posedge clock); #1;
          if (noise_en && $urandom_range(0, 1) == 1) begin
            term_valid = 1'b0; term_done = 1'b0;
            @(posedge clock); #1;
          end
        end
        term_valid = 1'b1; term_index = term_q[i].a; term_data = term_q[i].d;
        term_done = done_last && (i == n - 1);
      end
      if (n == 0 || !done_last) begin
        if (n > 0) begin @(posedge clock); #1; end
        term_valid = 1'b0; term_done = 1'b1;
      end
    end else begin
      term_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      term_done  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      term_index = 8'($urandom);
      term_data  = 8'($urandom);
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd9999;
      2: return 32'd10000;
      3: return 32'($urandom_range(0, 99));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference: decimal representation, units digit at the rightmost address, written first.
  function automatic void add_field_writes(input longint unsigned v, input logic [7:0] base);
    longint unsigned p = 1;
    for (int i = 0; i < D; i++) begin
      wr_t w;
      w.d = 8'h30 + 8'((v / p) % 10);
`ifdef SCREEN_FIELD_LEADING_BLANK_EN
      if (i > 0 && (v / p) == 0) w.d = 8'h20;
`endif
      w.a = base + 8'(D - 1 - i);
      w.c = 0;
      exp_q.push_back(w);
      p = p * 10;
    end
  endfunction

  function automatic void new_term();
    int n = $urandom_range(0, 3);
    term_q.delete();
    for (int i = 0; i < n; i++) term_q.push_back('{a: 8'($urandom), d: 8'($urandom), c: 0});
    done_last = 1'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({wr_en, wr_addr, wr_data, term_start, frame_done, busy} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {wr_en, wr_addr, wr_data, term_start, frame_done, busy});
    end
    @(posedge clock); #1;
    resetn = 1'b1; noise_en = 1'b1;
    repeat (6) @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || wq.size() != 0 || ts_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_run: busy=%b writes=%0d starts=%0d expected 0/0/0", busy, wq.size(), ts_cnt);
    end
    noise_en = 1'b0;
  endtask

  task automatic test_decimal_fields();
    logic [7:0] ea [8];
    logic [7:0] ed [8];
    int fd0, ts0, t;
    ea = '{8'h3F, 8'h3E, 8'h3D, 8'h3C, 8'h5F, 8'h5E, 8'h5D, 8'h5C};
`ifdef SCREEN_FIELD_LEADING_BLANK_EN
    ed = '{8'h32, 8'h34, 8'h20, 8'h20, 8'h36, 8'h35, 8'h34, 8'h33};
`else
    ed = '{8'h32, 8'h34, 8'h30, 8'h30, 8'h36, 8'h35, 8'h34, 8'h33};
`endif
    field_val = {32'd123456, 32'd42}; field_base = {8'h5C, 8'h3C};
    term_q.delete(); done_last = 1'b0; noise_en = 1'b0;
    wq.delete(); busy_cyc = 0; fd0 = fd_cnt; ts0 = ts_cnt;
    @(posedge clock); #1; run = 1'b1;
    for (t = 0; t < 50 && wq.size() < 1; t++) begin @(posedge clock); #1; end
    field_val[31:0] = 32'd7777;
    for (t = 0; t < 50 && wq.size() < 5; t++) begin @(posedge clock); #1; end
    field_val[63:32] = 32'd99; run = 1'b0;
    for (t = 0; t < 100 && fd_cnt == fd0; t++) begin @(posedge clock); #1; end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (wq.size() != 8) begin errors++; $display("FAIL dec_count: got %0d expected 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].d} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL dec_write[%0d]: got %h=%h expected %h=%h", i, wq[i].a, wq[i].d, ea[i], ed[i]);
      end
      checks++;
      if (wq[i].c != wq[0].c + i + i / D) begin
        errors++;
        $display("FAIL dec_timing[%0d]: got cycle %0d expected %0d", i, wq[i].c, wq[0].c + i + i / D);
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1 || ts_cnt - ts0 != 1) begin
      errors++;
      $display("FAIL dec_pulses: frame_done=%0d term_start=%0d expected 1/1", fd_cnt - fd0, ts_cnt - ts0);
    end
    checks++;
    if (busy_cyc != NF * (D + 1) + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dec_latency: busy cycles %0d busy=%b expected %0d/0", busy_cyc, busy, NF * (D + 1) + 2);
    end
  endtask

  task automatic test_terminal();
    int fd0, ts0, t;
    for (int k = 0; k < NF; k++) begin
      field_val[k*VW +: VW] = pick_val();
      field_base[k*AW +: AW] = 8'($urandom);
    end
    exp_q.delete();
    for (int k = 0; k < NF; k++) add_field_writes(field_val[k*VW +: VW], field_base[k*AW +: AW]);
    term_q.delete();
    for (int i = 0; i < 4; i++) term_q.push_back('{a: 8'($urandom), d: 8'($urandom), c: 0});
    for (int i = 0; i < 4; i++) exp_q.push_back(term_q[i]);
    done_last = 1'b1; noise_en = 1'b1;
    wq.delete(); fd0 = fd_cnt; ts0 = ts_cnt;
    @(posedge clock); #1; run = 1'b1;
    for (t = 0; t < 100 && ts_cnt == ts0; t++) begin @(posedge clock); #1; end
    run = 1'b0;
    for (t = 0; t < 100 && fd_cnt == fd0; t++) begin @(posedge clock); #1; end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (wq.size() != exp_q.size()) begin
      errors++; $display("FAIL term_count: got %0d expected %0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if ({wq[i].a, wq[i].d} !== {exp_q[i].a, exp_q[i].d}) begin
        errors++;
        $display("FAIL term_write[%0d]: got %h=%h expected %h=%h", i, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1 || ts_cnt - ts0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL term_pulses: frame_done=%0d term_start=%0d busy=%b expected 1/1/0", fd_cnt - fd0, ts_cnt - ts0, busy);
    end
    noise_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int fd0, ts0, t, m;
    field_val[31:0] = pick_val(); field_base[7:0] = 8'hFE;
    field_val[63:32] = 32'd0;     field_base[15:8] = 8'($urandom);
    new_term(); noise_en = 1'b1;
    wq.delete(); fd0 = fd_cnt; ts0 = ts_cnt;
    @(posedge clock); #1; run = 1'b1;
    for (int f = 0; f < NFR; f++) begin
      exp_q.delete();
      for (int k = 0; k < NF; k++) add_field_writes(field_val[k*VW +: VW], field_base[k*AW +: AW]);
      for (int i = 0; i < term_q.size(); i++) exp_q.push_back(term_q[i]);
      for (t = 0; t < 100 && ts_cnt <= ts0 + f; t++) begin @(posedge clock); #1; end
      if (f == NFR - 1) begin
        run = 1'b0;
      end else begin
        for (int k = 0; k < NF; k++) begin
          field_val[k*VW +: VW] = pick_val();
          field_base[k*AW +: AW] = 8'($urandom);
        end
      end
      for (t = 0; t < 100 && fd_cnt <= fd0 + f; t++) begin @(posedge clock); #1; end
      checks++;
      if (wq.size() != exp_q.size()) begin
        errors++; $display("FAIL b2b_count frame %0d: got %0d expected %0d", f, wq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        checks++;
        if ({wq[i].a, wq[i].d} !== {exp_q[i].a, exp_q[i].d}) begin
          errors++;
          $display("FAIL b2b_write[%0d] frame %0d: got %h=%h expected %h=%h", i, f, wq[i].a, wq[i].d, exp_q[i].a, exp_q[i].d);
        end
        if (i < NF * D) begin
          checks++;
          if (wq[i].c != wq[0].c + i + i / D) begin
            errors++;
            $display("FAIL b2b_timing[%0d] frame %0d: got %0d expected %0d", i, f, wq[i].c, wq[0].c + i + i / D);
          end
        end
      end
      m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
      repeat (m) void'(wq.pop_front());
      if (f < NFR - 1) new_term();
    end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (wq.size() != 0 || busy !== 1'b0 || fd_cnt - fd0 != NFR || ts_cnt - ts0 != NFR) begin
      errors++;
      $display("FAIL b2b_end: extra=%0d busy=%b frames=%0d starts=%0d expected 0/0/%0d/%0d",
               wq.size(), busy, fd_cnt - fd0, ts_cnt - ts0, NFR, NFR);
    end
    noise_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int fd0, t, n, rc;
    field_val = {32'd123456, 32'd42}; field_base = {8'h5C, 8'h3C};
    term_q.delete(); done_last = 1'b0; noise_en = 1'b0; wq.delete();
    @(posedge clock); #1; run = 1'b1;
    for (t = 0; t < 50 && wq.size() < 1; t++) begin @(posedge clock); #1; end
    resetn = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_immediate: wr_en=%b busy=%b expected 0/0", wr_en, busy);
    end
    n = wq.size();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (wq.size() != n) begin errors++; $display("FAIL rst_no_writes: got %0d expected %0d", wq.size(), n); end
    fd0 = fd_cnt;
    resetn = 1'b1; rc = cyc;
    for (t = 0; t < 50 && wq.size() <= n; t++) begin @(posedge clock); #1; end
    run = 1'b0;
    checks++;
    if (wq.size() <= n) begin
      errors++; $display("FAIL rst_resume: got no write expected 3f=32");
    end else if ({wq[n].a, wq[n].d} !== 16'h3F32 || wq[n].c != rc + 2) begin
      errors++;
      $display("FAIL rst_resume: got %h=%h at %0d expected 3f=32 at %0d", wq[n].a, wq[n].d, wq[n].c, rc + 2);
    end
    for (t = 0; t < 100 && fd_cnt == fd0; t++) begin @(posedge clock); #1; end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (wq.size() - n != NF * D || busy !== 1'b0) begin
      errors++; $display("FAIL rst_frame: writes=%0d busy=%b expected %0d/0", wq.size() - n, busy, NF * D);
    end
  endtask

  initial begin
    #1 resetn = 1'b0;
    test_reset();
    test_decimal_fields();
    test_terminal();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
